// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types and sizing.
// Entry layout used by the in-order retirement buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 32;
  localparam int ROB_TAG_W  = 5;
  localparam int ROB_PREG_W = 7;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
    logic [31:0] pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete
// out of order, retire one per cycle at head, truncate on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int PREG_W = ROB_PREG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rob_we_in,
  input  logic [PREG_W-1:0] pd_new_in,
  input  logic [PREG_W-1:0] pd_old_in,
  input  logic [31:0]       pc_in,
  output logic [TAG_W-1:0]  rob_tag_out,
  output logic              rob_full_out,
  output logic [TAG_W-1:0]  head_tag_out,
  output logic              rob_empty_out,
  input  logic              cmpl_valid [0:2],
  input  logic [TAG_W-1:0]  cmpl_tag [0:2],
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              commit_valid_out,
  output logic [TAG_W-1:0]  commit_tag_out,
  output logic [PREG_W-1:0] commit_pd_old_out,
  output logic [PREG_W-1:0] commit_pd_new_out,
  output logic [31:0]       commit_pc_out
);

  rob_entry_t       rob [DEPTH];
  rob_entry_t       head_e;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             full;
  logic             alloc;
  logic             commit;
  logic [TAG_W-1:0] br_age;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] hit;

  assign head_e = rob[head];
  assign full   = count == (TAG_W+1)'(DEPTH);
  assign alloc  = rob_we_in && !full && !mispredict;
  assign commit = head_e.valid && head_e.done && !mispredict;
  assign br_age = mispredict_tag - head;

  // Age relative to head; anything older-than-branch survives.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [TAG_W-1:0] IDX = TAG_W'(i);
    logic [TAG_W-1:0] age;
    assign age     = IDX - head;
    assign kill[i] = mispredict && (age > br_age);
    assign hit[i]  = (cmpl_valid[0] && cmpl_tag[0] == IDX)
                  || (cmpl_valid[1] && cmpl_tag[1] == IDX)
                  || (cmpl_valid[2] && cmpl_tag[2] == IDX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          rob[i].valid <= 1'b0;
          rob[i].done  <= 1'b0;
        end else if (alloc && tail == TAG_W'(i)) begin
          rob[i] <= '{valid: 1'b1, done: 1'b0,
                      pd_new: pd_new_in,
                      pd_old: pd_old_in,
                      pc: pc_in};
        end else if (commit && head == TAG_W'(i)) begin
          rob[i].valid <= 1'b0;
          rob[i].done  <= 1'b0;
        end else if (hit[i] && rob[i].valid) begin
          rob[i].done <= 1'b1;
        end
      end
      if (mispredict) begin
        tail  <= mispredict_tag + TAG_W'(1);
        count <= {1'b0, br_age} + (TAG_W+1)'(1);
      end else begin
        if (alloc)  tail <= tail + TAG_W'(1);
        if (commit) head <= head + TAG_W'(1);
        count <= count + (TAG_W+1)'(alloc)
                       - (TAG_W+1)'(commit);
      end
    end
  end

  assign rob_tag_out       = tail;
  assign rob_full_out      = full;
  assign head_tag_out      = head;
  assign rob_empty_out     = count == '0;
  assign commit_valid_out  = commit;
  assign commit_tag_out    = head_e.valid ? head : '0;
  assign commit_pd_old_out = head_e.valid ? head_e.pd_old : '0;
  assign commit_pd_new_out = head_e.valid ? head_e.pd_new : '0;
  assign commit_pc_out     = head_e.valid ? head_e.pc : '0;

  mispredict_tag_valid: assert property (
    @(posedge clk) disable iff (!reset)
    mispredict |-> rob[mispredict_tag].valid
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios
// plus randomized traffic against a queue-style reference model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rob_we_in;
  logic [6:0]  pd_new_in;
  logic [6:0]  pd_old_in;
  logic [31:0] pc_in;
  logic [4:0]  rob_tag_out;
  logic        rob_full_out;
  logic [4:0]  head_tag_out;
  logic        rob_empty_out;
  logic        cmpl_valid [0:2];
  logic [4:0]  cmpl_tag [0:2];
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        commit_valid_out;
  logic [4:0]  commit_tag_out;
  logic [6:0]  commit_pd_old_out;
  logic [6:0]  commit_pd_new_out;
  logic [31:0] commit_pc_out;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk),
    .reset(reset),
    .rob_we_in(rob_we_in),
    .pd_new_in(pd_new_in),
    .pd_old_in(pd_old_in),
    .pc_in(pc_in),
    .rob_tag_out(rob_tag_out),
    .rob_full_out(rob_full_out),
    .head_tag_out(head_tag_out),
    .rob_empty_out(rob_empty_out),
    .cmpl_valid(cmpl_valid),
    .cmpl_tag(cmpl_tag),
    .mispredict(mispredict),
    .mispredict_tag(mispredict_tag),
    .commit_valid_out(commit_valid_out),
    .commit_tag_out(commit_tag_out),
    .commit_pd_old_out(commit_pd_old_out),
    .commit_pd_new_out(commit_pd_new_out),
    .commit_pc_out(commit_pc_out)
  );

  bit          m_valid [D];
  bit          m_done [D];
  logic [6:0]  m_pdn [D];
  logic [6:0]  m_pdo [D];
  logic [31:0] m_pc [D];
  int          m_head, m_tail, m_count;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic idle();
    rob_we_in      = 1'b0;
    pd_new_in      = '0;
    pd_old_in      = '0;
    pc_in          = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    for (int k = 0; k < 3; k++) begin
      cmpl_valid[k] = 1'b0;
      cmpl_tag[k]   = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 0;
      m_done[i]  = 0;
      m_pdn[i]   = '0;
      m_pdo[i]   = '0;
      m_pc[i]    = '0;
    end
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
  endtask

  // Next state from the current inputs, applied at the coming edge.
  task automatic model_edge();
    bit          cm, al;
    bit [D-1:0]  cd;
    int          j, t;
    cm = m_valid[m_head] && m_done[m_head] && !mispredict;
    al = rob_we_in && (m_count < D) && !mispredict;
    cd = '0;
    for (int k = 0; k < 3; k++)
      if (cmpl_valid[k] && m_valid[cmpl_tag[k]]) cd[cmpl_tag[k]] = 1'b1;
    if (mispredict) begin
      t = int'(mispredict_tag);
      j = (t + 1) % D;
      while (j != m_tail) begin
        m_valid[j] = 0;
        m_done[j]  = 0;
        cd[j]      = 1'b0;
        j = (j + 1) % D;
      end
      m_tail  = (t + 1) % D;
      m_count = ((t - m_head + D) % D) + 1;
    end
    for (int i = 0; i < D; i++) if (cd[i]) m_done[i] = 1;
    if (cm) begin
      m_valid[m_head] = 0;
      m_done[m_head]  = 0;
      m_head = (m_head + 1) % D;
    end
    if (al) begin
      m_valid[m_tail] = 1;
      m_done[m_tail]  = 0;
      m_pdn[m_tail]   = pd_new_in;
      m_pdo[m_tail]   = pd_old_in;
      m_pc[m_tail]    = pc_in;
      m_tail = (m_tail + 1) % D;
    end
    if (!mispredict) m_count = m_count + int'(al) - int'(cm);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic do_alloc(input int pdn, input int pdo, input int pc);
    rob_we_in = 1'b1;
    pd_new_in = pdn[6:0];
    pd_old_in = pdo[6:0];
    pc_in     = pc;
    tick();
    rob_we_in = 1'b0;
  endtask

  task automatic do_cmpl(input int k, input int t);
    cmpl_valid[k] = 1'b1;
    cmpl_tag[k]   = t[4:0];
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_total++;
    if ({rob_tag_out, rob_full_out, head_tag_out, rob_empty_out} !== {5'd0, 1'b0, 5'd0, 1'b1})
      $display("FAIL reset_status: got tag=%0d full=%0b head=%0d empty=%0b want 0 0 0 1",
               rob_tag_out, rob_full_out, head_tag_out, rob_empty_out);
    else n_pass++;
    n_total++;
    if ({commit_valid_out, commit_tag_out, commit_pd_old_out, commit_pd_new_out, commit_pc_out} !== '0)
      $display("FAIL reset_commit: got v=%0b tag=%0d old=%0d new=%0d pc=%h want all 0",
               commit_valid_out, commit_tag_out, commit_pd_old_out, commit_pd_new_out, commit_pc_out);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_alloc();
    for (int i = 0; i < 3; i++) begin
      rob_we_in = 1'b1;
      pd_new_in = 7'(40 + i);
      pd_old_in = 7'(1 + i);
      pc_in     = 32'h1000 + 32'(4 * i);
      #1;
      n_total++;
      if (rob_tag_out !== 5'(i))
        $display("FAIL alloc_tag: got %0d want %0d", rob_tag_out, i);
      else n_pass++;
      tick();
    end
    idle();
    #1;
    n_total++;
    if ({rob_tag_out, head_tag_out, rob_empty_out, commit_valid_out} !== {5'd3, 5'd0, 1'b0, 1'b0})
      $display("FAIL alloc_after3: got tag=%0d head=%0d empty=%0b cv=%0b want 3 0 0 0",
               rob_tag_out, head_tag_out, rob_empty_out, commit_valid_out);
    else n_pass++;
  endtask

  task automatic test_complete_order();
    do_cmpl(0, 1);
    #1;
    n_total++;
    if (commit_valid_out !== 1'b0)
      $display("FAIL ooo_no_commit: got %0b want 0", commit_valid_out);
    else n_pass++;
    tick();
    idle();
    do_cmpl(2, 0);
    #1;
    n_total++;
    if (commit_valid_out !== 1'b0)
      $display("FAIL same_cycle_cmpl: got %0b want 0", commit_valid_out);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if ({commit_valid_out, commit_tag_out, commit_pd_old_out, commit_pd_new_out, commit_pc_out}
        !== {1'b1, 5'd0, 7'd1, 7'd40, 32'h1000})
      $display("FAIL commit_tag0: got v=%0b tag=%0d old=%0d new=%0d pc=%h want 1 0 1 40 1000",
               commit_valid_out, commit_tag_out, commit_pd_old_out, commit_pd_new_out, commit_pc_out);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if ({commit_valid_out, commit_tag_out, commit_pd_old_out, commit_pd_new_out}
        !== {1'b1, 5'd1, 7'd2, 7'd41})
      $display("FAIL commit_tag1: got v=%0b tag=%0d old=%0d new=%0d want 1 1 2 41",
               commit_valid_out, commit_tag_out, commit_pd_old_out, commit_pd_new_out);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({commit_valid_out, head_tag_out, commit_pd_old_out, rob_empty_out} !== {1'b0, 5'd2, 7'd3, 1'b0})
      $display("FAIL tag2_waits: got cv=%0b head=%0d old=%0d empty=%0b want 0 2 3 0",
               commit_valid_out, head_tag_out, commit_pd_old_out, rob_empty_out);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < D; i++) do_alloc(i + 10, i, 32'h2000 + i * 4);
    n_total++;
    if ({rob_full_out, rob_tag_out, head_tag_out} !== {1'b1, 5'd0, 5'd0})
      $display("FAIL full_after32: got full=%0b tag=%0d head=%0d want 1 0 0",
               rob_full_out, rob_tag_out, head_tag_out);
    else n_pass++;
    do_alloc(99, 99, 32'hdead);
    n_total++;
    if ({rob_full_out, rob_tag_out, head_tag_out} !== {1'b1, 5'd0, 5'd0})
      $display("FAIL alloc_when_full: got full=%0b tag=%0d head=%0d want 1 0 0",
               rob_full_out, rob_tag_out, head_tag_out);
    else n_pass++;
    do_cmpl(0, 0);
    do_cmpl(1, 1);
    tick();
    idle();
    rob_we_in = 1'b1;
    pd_new_in = 7'd77;
    #1;
    n_total++;
    if ({commit_valid_out, commit_tag_out} !== {1'b1, 5'd0})
      $display("FAIL full_commit: got v=%0b tag=%0d want 1 0", commit_valid_out, commit_tag_out);
    else n_pass++;
    tick();
    n_total++;
    if ({rob_full_out, head_tag_out, rob_tag_out} !== {1'b0, 5'd1, 5'd0})
      $display("FAIL full_commit_after: got full=%0b head=%0d tag=%0d want 0 1 0",
               rob_full_out, head_tag_out, rob_tag_out);
    else n_pass++;
    #1;
    n_total++;
    if ({commit_valid_out, commit_tag_out, rob_tag_out} !== {1'b1, 5'd1, 5'd0})
      $display("FAIL wrap_alloc_commit: got v=%0b ctag=%0d tag=%0d want 1 1 0",
               commit_valid_out, commit_tag_out, rob_tag_out);
    else n_pass++;
    tick();
    idle();
    n_total++;
    if ({rob_tag_out, head_tag_out, rob_full_out} !== {5'd1, 5'd2, 1'b0})
      $display("FAIL wrap_after: got tag=%0d head=%0d full=%0b want 1 2 0",
               rob_tag_out, head_tag_out, rob_full_out);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    apply_reset();
    for (int i = 0; i < 10; i++) do_alloc(i + 50, i + 1, 32'h3000 + i * 4);
    mispredict     = 1'b1;
    mispredict_tag = 5'd4;
    do_cmpl(0, 7);
    tick();
    idle();
    n_total++;
    if ({rob_tag_out, head_tag_out, rob_empty_out, rob_full_out} !== {5'd5, 5'd0, 1'b0, 1'b0})
      $display("FAIL flush_ptrs: got tag=%0d head=%0d empty=%0b full=%0b want 5 0 0 0",
               rob_tag_out, head_tag_out, rob_empty_out, rob_full_out);
    else n_pass++;
    for (int i = 0; i < 26; i++) do_alloc(i, i, i);
    n_total++;
    if (rob_full_out !== 1'b0)
      $display("FAIL flush_count31: got full=%0b want 0", rob_full_out);
    else n_pass++;
    do_alloc(1, 1, 1);
    n_total++;
    if ({rob_full_out, rob_tag_out} !== {1'b1, 5'd0})
      $display("FAIL flush_count32: got full=%0b tag=%0d want 1 0", rob_full_out, rob_tag_out);
    else n_pass++;
  endtask

  task automatic test_commit_vs_mispredict();
    apply_reset();
    for (int i = 0; i < 3; i++) do_alloc(i + 20, i + 5, 32'h4000 + i * 4);
    do_cmpl(0, 0);
    tick();
    idle();
    mispredict     = 1'b1;
    mispredict_tag = 5'd1;
    #1;
    n_total++;
    if (commit_valid_out !== 1'b0)
      $display("FAIL mp_blocks_commit: got %0b want 0", commit_valid_out);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if ({commit_valid_out, commit_tag_out, rob_tag_out} !== {1'b1, 5'd0, 5'd2})
      $display("FAIL commit_after_mp: got v=%0b ctag=%0d tag=%0d want 1 0 2",
               commit_valid_out, commit_tag_out, rob_tag_out);
    else n_pass++;
    tick();
    n_total++;
    if ({head_tag_out, commit_valid_out} !== {5'd1, 1'b0})
      $display("FAIL head_after_mp: got head=%0d v=%0b want 1 0", head_tag_out, commit_valid_out);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) do_alloc(i + 30, i + 8, 32'h5000 + i * 4);
    do_cmpl(1, 0);
    tick();
    idle();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({rob_tag_out, rob_full_out, head_tag_out, rob_empty_out, commit_valid_out,
         commit_tag_out, commit_pd_old_out, commit_pd_new_out, commit_pc_out}
        !== {5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 7'd0, 7'd0, 32'd0})
      $display("FAIL async_reset: got tag=%0d full=%0b head=%0d empty=%0b cv=%0b old=%0d want 0 0 0 1 0 0",
               rob_tag_out, rob_full_out, head_tag_out, rob_empty_out, commit_valid_out, commit_pd_old_out);
    else n_pass++;
    #1;
    reset = 1'b1;
    tick();
    n_total++;
    if ({rob_empty_out, commit_valid_out} !== {1'b1, 1'b0})
      $display("FAIL post_reset: got empty=%0b cv=%0b want 1 0", rob_empty_out, commit_valid_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] exp_v, act_v;
    int          h;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        rob_we_in = 1'b1;
        pd_new_in = 7'($urandom);
        pd_old_in = 7'($urandom);
        pc_in     = $urandom;
      end
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          cmpl_valid[k] = 1'b1;
          if (m_count > 0 && $urandom_range(0, 3) != 0)
            cmpl_tag[k] = 5'((m_head + int'($urandom_range(0, m_count - 1))) % D);
          else
            cmpl_tag[k] = 5'($urandom);
        end
      end
      if (m_count > 0 && $urandom_range(0, 15) == 0) begin
        mispredict     = 1'b1;
        mispredict_tag = 5'((m_head + int'($urandom_range(0, m_count - 1))) % D);
      end
      #1;
      h = m_head;
      exp_v = {5'(m_tail), (m_count == D), 5'(h), (m_count == 0),
               (m_valid[h] && m_done[h] && !mispredict),
               (m_valid[h] ? 5'(h) : 5'd0),
               (m_valid[h] ? m_pdo[h] : 7'd0),
               (m_valid[h] ? m_pdn[h] : 7'd0),
               (m_valid[h] ? m_pc[h] : 32'd0)};
      act_v = {rob_tag_out, rob_full_out, head_tag_out, rob_empty_out, commit_valid_out,
               commit_tag_out, commit_pd_old_out, commit_pd_new_out, commit_pc_out};
      n_total++;
      if (act_v !== exp_v)
        $display("FAIL random_cycle%0d: got %h want %h", c, act_v, exp_v);
      else n_pass++;
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alloc();
    test_complete_order();
    test_full_wrap();
    test_mispredict();
    test_commit_vs_mispredict();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
